hawk_video_meta_sched: RTL and testbench

- Per-frame scheduler for the in-band metadata word that the video insertion stage places on the first data beat after SOP.
- Monitors the Avalon-ST video stream on stream_clk and shares the single metadata slot among NUM_SRC requesters (temperature, exposure, status, ...) using round-robin.
- Latches the winner's word at frame start, holds it stable for the whole frame, and gates insertion at frame boundaries only.
- Counts frames and checks frame geometry against SIZE_X*SIZE_Y.

---
 rtl/hawk_video_pkg.sv | 8 +
 rtl/hawk_rr_arbiter.sv | 25 ++
 rtl/hawk_video_meta_sched.sv | 112 +++++++++++
 tb/tb_hawk_video_meta_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hawk_video_pkg.sv
// hawk_video_pkg: shared frame geometry defaults and scheduler state type
package hawk_video_pkg;
   localparam int SIZE_X = 640;
   localparam int SIZE_Y = 480;
   localparam int PIX_TOTAL = SIZE_X * SIZE_Y;
   localparam int PW = $clog2(PIX_TOTAL + 1);
   typedef enum logic {IDLE, ACTIVE} state_t;
endpackage

// File: rtl/hawk_rr_arbiter.sv
// hawk_rr_arbiter: combinational round-robin pick, searching from ptr+1 and wrapping
module hawk_rr_arbiter #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] gnt_idx,
   output logic         gnt_any
);
   logic [W-1:0] idx;
   // Walk candidates farthest-first so the nearest requester after ptr overwrites last
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx = '0;
      for (int i = N; i >= 1; i--) begin
         idx = W'((int'(ptr) + i) % N);
         if (req[idx]) begin
            gnt_idx = idx;
            gnt_any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/hawk_video_meta_sched.sv
// hawk_video_meta_sched: per-frame metadata slot scheduler with frame counting and geometry check
module hawk_video_meta_sched #(
   parameter int SIZE_X  = hawk_video_pkg::SIZE_X,
   parameter int SIZE_Y  = hawk_video_pkg::SIZE_Y,
   parameter int NUM_SRC = 4,
   parameter int FCNT_W  = 16
) (
   input  logic                       stream_clk,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic [NUM_SRC-1:0]         src_valid,
   input  logic [16*NUM_SRC-1:0]      src_data,
   output logic [NUM_SRC-1:0]         src_ack,
   input  logic                       stream_in_sop,
   input  logic                       stream_in_valid,
   input  logic                       stream_in_eop,
   output logic                       insert_en,
   output logic [15:0]                meta_data,
   output logic [$clog2(NUM_SRC)-1:0] meta_tag,
   output logic                       meta_valid,
   output logic [FCNT_W-1:0]          frame_cnt,
   output logic                       frame_err
);
   import hawk_video_pkg::*;
   localparam int FRAME_PIX = SIZE_X * SIZE_Y;
   localparam int CNT_W = $clog2(FRAME_PIX + 1);
   localparam int TW = $clog2(NUM_SRC);
   state_t state_q, state_d;
   logic [CNT_W-1:0] pix_q, pix_d, pix_inc;
   logic [TW-1:0] rr_q, rr_d, tag_q, tag_d, gnt_idx;
   logic [15:0] data_q, data_d;
   logic [NUM_SRC-1:0] ack_q, ack_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic ins_q, ins_d, mv_q, mv_d, err_q, err_d, gnt_any;
   logic sop_beat, data_beat, eop_beat;
   assign sop_beat  = stream_in_valid & stream_in_sop;
   assign data_beat = stream_in_valid & ~stream_in_sop;
   assign eop_beat  = stream_in_valid & stream_in_eop;
   assign pix_inc   = (&pix_q) ? pix_q : pix_q + 1'b1;
   hawk_rr_arbiter #(.N(NUM_SRC)) u_arb (
      .req     (src_valid),
      .ptr     (rr_q),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );
   // A sop_beat always starts a frame; sop+eop together closes it again as a zero-pixel frame
   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      rr_d    = rr_q;
      tag_d   = tag_q;
      data_d  = data_q;
      ins_d   = ins_q;
      mv_d    = mv_q;
      ack_d   = '0;
      fcnt_d  = fcnt_q;
      err_d   = 1'b0;
      if (sop_beat) begin
         pix_d   = '0;
         ins_d   = enable;
         data_d  = gnt_any ? src_data[16*gnt_idx +: 16] : 16'h0;
         mv_d    = gnt_any;
         if (gnt_any) begin
            tag_d = gnt_idx;
            rr_d  = gnt_idx;
            ack_d[gnt_idx] = 1'b1;
         end
         state_d = eop_beat ? IDLE : ACTIVE;
         err_d   = eop_beat || state_q == ACTIVE;
         fcnt_d  = eop_beat ? fcnt_q + 1'b1 : fcnt_q;
      end else if (state_q == ACTIVE && data_beat) begin
         pix_d = pix_inc;
         if (eop_beat) begin
            state_d = IDLE;
            fcnt_d  = fcnt_q + 1'b1;
            err_d   = pix_inc != CNT_W'(FRAME_PIX);
         end
      end
   end
   always_ff @(posedge stream_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pix_q   <= '0;
         rr_q    <= TW'(NUM_SRC - 1);
         tag_q   <= '0;
         data_q  <= '0;
         ins_q   <= 1'b0;
         mv_q    <= 1'b0;
         ack_q   <= '0;
         fcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         rr_q    <= rr_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         ins_q   <= ins_d;
         mv_q    <= mv_d;
         ack_q   <= ack_d;
         fcnt_q  <= fcnt_d;
         err_q   <= err_d;
      end
   end
   assign insert_en  = ins_q;
   assign meta_data  = data_q;
   assign meta_tag   = tag_q;
   assign meta_valid = mv_q;
   assign src_ack    = ack_q;
   assign frame_cnt  = fcnt_q;
   assign frame_err  = err_q;
endmodule

// File: tb/tb_hawk_video_meta_sched.sv
// tb_hawk_video_meta_sched: vector table, directed frame sequences and random beats vs a frame-level model
module tb_hawk_video_meta_sched;
   localparam int SX = 8, SY = 4, PIX = SX * SY, N = 4, FW = 4;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, v = 1'b0, s = 1'b0, e = 1'b0;
   logic [N-1:0] srcv = '0;
   logic [16*N-1:0] srcd = '0;
   logic [N-1:0] ack;
   logic ins, mv, err;
   logic [15:0] md;
   logic [1:0] tag;
   logic [FW-1:0] fcnt;
   int errors = 0, checks = 0, n_err = 0, n_ack = 0;
   logic m_in, m_ins, m_mv, m_err;
   logic [15:0] m_data;
   logic [N-1:0] m_ack;
   logic [FW-1:0] m_fcnt;
   int m_tag, m_rr, m_cnt;

   typedef struct {
      logic v, s, e, en;
      logic [3:0] sv;
      logic x_err;
      logic [3:0] x_fcnt;
      logic x_ins, x_mv;
      logic [1:0] x_tag;
   } vec_t;
   vec_t tbl[8];

   hawk_video_meta_sched #(.SIZE_X(SX), .SIZE_Y(SY), .NUM_SRC(N), .FCNT_W(FW)) dut (
      .stream_clk      (clk),
      .reset_n         (rst_n),
      .enable          (en),
      .src_valid       (srcv),
      .src_data        (srcd),
      .src_ack         (ack),
      .stream_in_sop   (s),
      .stream_in_valid (v),
      .stream_in_eop   (e),
      .insert_en       (ins),
      .meta_data       (md),
      .meta_tag        (tag),
      .meta_valid      (mv),
      .frame_cnt       (fcnt),
      .frame_err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_in = 0; m_ins = 0; m_mv = 0; m_err = 0; m_data = 0; m_ack = 0;
      m_fcnt = 0; m_tag = 0; m_rr = N - 1; m_cnt = 0;
   endtask

   // Frame-level view: a frame opens on SOP, counts non-SOP beats, closes on EOP
   task automatic model_step();
      m_ack = '0;
      m_err = 0;
      if (v && s) begin
         if (m_in) m_err = 1;
         m_ins = en; m_cnt = 0; m_mv = 0; m_data = 0;
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (srcv[j]) begin
               m_mv = 1; m_data = srcd[16*j +: 16]; m_tag = j; m_rr = j; m_ack[j] = 1'b1;
               break;
            end
         end
         if (e) begin m_err = 1; m_fcnt++; m_in = 0; end
         else m_in = 1;
      end else if (v && m_in) begin
         m_cnt++;
         if (e) begin m_fcnt++; m_in = 0; m_err = (m_cnt != PIX); end
      end
   endtask

   task automatic check_all();
      chk("insert_en", ins, m_ins);
      chk("meta_data", md, m_data);
      chk("meta_tag", tag, m_tag);
      chk("meta_valid", mv, m_mv);
      chk("src_ack", ack, m_ack);
      chk("frame_cnt", fcnt, m_fcnt);
      chk("frame_err", err, m_err);
   endtask

   task automatic beat(input logic bv, input logic bs, input logic be);
      v = bv; s = bs; e = be;
      @(posedge clk);
      model_step();
      #1;
      check_all();
      n_err += int'(err);
      n_ack += $countones(ack);
   endtask

   task automatic do_reset();
      v = 0; s = 0; e = 0;
      rst_n = 1'b0;
      model_reset();
      #2;
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   task automatic frame(input int n);
      beat(1, 1, 0);
      for (int i = 1; i < n; i++) beat(1, 0, 0);
      beat(1, 0, 1);
   endtask

   initial begin
      tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 4'd1, 1'b1, 1'b1, 2'd2};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 4'd1, 1'b1, 1'b1, 2'd2};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, 4'd1, 1'b0, 1'b1, 2'd1};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, 4'd1, 1'b1, 1'b0, 2'd1};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 4'd2, 1'b1, 1'b0, 2'd1};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'd2, 1'b1, 1'b0, 2'd1};
      srcd = {16'h4D4D, 16'h3C3C, 16'h2B2B, 16'h1A2B};
      do_reset();
      chk("rst_fcnt", fcnt, 0);
      chk("rst_tag", tag, 0);
      // single requester, two good frames
      en = 1; srcv = 4'b0001; n_err = 0; n_ack = 0;
      frame(PIX);
      beat(0, 0, 0);
      frame(PIX);
      chk("two_fcnt", fcnt, 2);
      chk("two_data", md, 16'h1A2B);
      chk("two_mv", mv, 1);
      chk("two_acks", n_ack, 2);
      chk("two_errs", n_err, 0);
      // round-robin order from reset
      do_reset();
      srcv = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         beat(1, 1, 0);
         chk("rr_tag", tag, f % 4);
         chk("rr_ack", ack, 1 << (f % 4));
         beat(1, 0, 0);
         chk("rr_ack_len", ack, 0);
         for (int i = 2; i < PIX; i++) beat(1, 0, 0);
         beat(1, 0, 1);
      end
      // short frame then a good one
      n_err = 0;
      frame(PIX - 1);
      chk("short_errs", n_err, 1);
      chk("short_fcnt", fcnt, 6);
      frame(PIX);
      chk("good_errs", n_err, 1);
      chk("good_fcnt", fcnt, 7);
      // missing EOP
      srcv = 4'b0101;
      beat(1, 1, 0);
      chk("noeop_tag0", tag, 0);
      for (int i = 0; i < 1000; i++) beat(1, 0, 0);
      beat(1, 1, 0);
      chk("noeop_err", err, 1);
      chk("noeop_fcnt", fcnt, 7);
      chk("noeop_tag1", tag, 2);
      for (int i = 1; i < PIX; i++) beat(1, 0, 0);
      beat(1, 0, 1);
      chk("restart_err", err, 0);
      chk("restart_fcnt", fcnt, 8);
      // enable changes only at SOP; empty request set
      en = 0; srcv = 4'b0000;
      beat(1, 1, 0);
      chk("nosrc_mv", mv, 0);
      chk("nosrc_data", md, 0);
      chk("en0_ins", ins, 0);
      repeat (3) beat(1, 0, 0);
      en = 1;
      repeat (3) beat(1, 0, 0);
      chk("en_mid_ins", ins, 0);
      for (int i = 7; i < PIX; i++) beat(1, 0, 0);
      beat(1, 0, 1);
      beat(0, 0, 0);
      chk("en_gap_ins", ins, 0);
      beat(1, 1, 0);
      chk("en1_ins", ins, 1);
      for (int i = 1; i < PIX; i++) beat(1, 0, 0);
      beat(1, 0, 1);
      // reset mid-frame, stray beats, then a clean frame
      srcv = 4'b1111;
      beat(1, 1, 0);
      repeat (5) beat(1, 0, 0);
      do_reset();
      chk("rst_mid_ins", ins, 0);
      chk("rst_mid_mv", mv, 0);
      chk("rst_mid_data", md, 0);
      chk("rst_mid_ack", ack, 0);
      beat(1, 0, 1);
      beat(1, 0, 0);
      chk("stray_fcnt", fcnt, 0);
      chk("stray_err", err, 0);
      srcv = 4'b0010; n_err = 0;
      frame(PIX);
      chk("post_rst_fcnt", fcnt, 1);
      chk("post_rst_errs", n_err, 0);
      chk("post_rst_tag", tag, 1);
      // vector table from reset
      do_reset();
      for (int i = 0; i < 8; i++) begin
         en = tbl[i].en;
         srcv = tbl[i].sv;
         beat(tbl[i].v, tbl[i].s, tbl[i].e);
         chk($sformatf("tbl%0d_err", i), err, tbl[i].x_err);
         chk($sformatf("tbl%0d_fcnt", i), fcnt, tbl[i].x_fcnt);
         chk($sformatf("tbl%0d_ins", i), ins, tbl[i].x_ins);
         chk($sformatf("tbl%0d_mv", i), mv, tbl[i].x_mv);
         chk($sformatf("tbl%0d_tag", i), tag, tbl[i].x_tag);
      end
      // random traffic mixed with well-formed frames
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < 60; i++) begin
            en = 1'($urandom);
            srcv = 4'($urandom);
            srcd = {$urandom, $urandom};
            beat($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, PIX) == 0);
         end
         srcv = 4'($urandom);
         frame(PIX);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
